// File: rtl/day_11_down_counter_with_reload.sv
// Loadable down-counter/timer with programmable prescaler, pause/stop control
// and optional auto-reload; done_o pulses for one cycle at terminal count.
module day_11_down_counter_with_reload #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [PW-1:0]    prescale_i,
  input  logic             auto_reload_i,
  input  logic             pause_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic [PW-1:0]    pcnt, pcnt_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      reload_q <= '0;
      presc_q  <= '0;
      pcnt     <= '0;
      count_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      reload_q <= reload_n;
      presc_q  <= presc_n;
      pcnt     <= pcnt_n;
      count_o  <= count_n;
      busy_o   <= (state_n != IDLE);
      done_o   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    reload_n = reload_q;
    presc_n  = presc_q;
    pcnt_n   = pcnt;
    count_n  = count_o;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (load_val_i != '0) begin
            count_n  = load_val_i;
            reload_n = load_val_i;
            presc_n  = prescale_i;
            pcnt_n   = '0;
            state_n  = RUN;
          end else begin
            count_n = '0;
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        // stop and pause both pre-empt a tick falling in the same cycle
        if (stop_i) begin
          state_n = IDLE;
        end else if (pause_i) begin
          state_n = HOLD;
        end else if (pcnt != presc_q) begin
          pcnt_n = pcnt + PW'(1);
        end else begin
          pcnt_n = '0;
          if (count_o > WIDTH'(1)) begin
            count_n = count_o - WIDTH'(1);
          end else begin
            done_n = 1'b1;
            if (auto_reload_i) begin
              count_n = reload_q;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
      HOLD: begin
        if (stop_i) begin
          state_n = IDLE;
        end else if (!pause_i) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_day_11_down_counter_with_reload.sv
// Directed-vector bench for day_11_down_counter_with_reload (WIDTH=PW=4).
module tb_day_11_down_counter_with_reload;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i, auto_reload_i, pause_i, stop_i;
  logic [3:0] load_val_i, prescale_i;
  logic [3:0] count_o;
  logic       busy_o, done_o;

  int vectors = 0;
  int miscompares = 0;

  day_11_down_counter_with_reload #(.WIDTH(4), .PW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .load_val_i    (load_val_i),
    .prescale_i    (prescale_i),
    .auto_reload_i (auto_reload_i),
    .pause_i       (pause_i),
    .stop_i        (stop_i),
    .count_o       (count_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input int b, input int d);
    check({tag, ".count"}, 32'(count_o), 32'(c));
    check({tag, ".busy"},  32'(busy_o),  32'(b));
    check({tag, ".done"},  32'(done_o),  32'(d));
  endtask

  task automatic start_run(input int l, input int p, input logic a);
    load_val_i    = 4'(l);
    prescale_i    = 4'(p);
    auto_reload_i = a;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  int one_shot [4] = '{4, 3, 2, 1};
  int reload_seq [18] = '{3, 3, 2, 2, 2, 1, 1, 1, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
  int edges;
  bit seen;

  initial begin
    reset = 1'b0; start_i = 1'b0; auto_reload_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0;
    load_val_i = '0; prescale_i = '0;
    #12;
    expect_out("reset", 0, 0, 0);
    reset = 1'b1;
    tick();

    // one-shot L=5 P=0
    start_run(5, 0, 1'b0);
    expect_out("os_start", 5, 1, 0);
    foreach (one_shot[i]) begin
      tick();
      expect_out("os_step", one_shot[i], 1, 0);
    end
    tick();
    expect_out("os_term", 0, 0, 1);
    tick();
    expect_out("os_after", 0, 0, 0);

    // prescale 2 with auto-reload; spurious start during RUN; auto dropped late
    start_run(3, 2, 1'b1);
    expect_out("rl_start", 3, 1, 0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 4) begin
        start_i = 1'b1; load_val_i = 4'd9;
      end
      if (k == 18) auto_reload_i = 1'b0;
      tick();
      start_i = 1'b0;
      expect_out("rl_step", reload_seq[k-1], (k == 18) ? 0 : 1, (k == 9 || k == 18) ? 1 : 0);
    end

    // pause for one cycle, then stop at count 2
    start_run(4, 0, 1'b0);
    tick();
    expect_out("pz_3", 3, 1, 0);
    pause_i = 1'b1;
    tick();
    expect_out("pz_hold", 3, 1, 0);
    pause_i = 1'b0;
    tick();
    expect_out("pz_resume", 3, 1, 0);
    tick();
    expect_out("pz_2", 2, 1, 0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    expect_out("stop", 2, 0, 0);
    tick();
    expect_out("stop_idle", 2, 0, 0);

    // stop and pause together in RUN
    start_run(4, 0, 1'b0);
    tick();
    stop_i = 1'b1; pause_i = 1'b1;
    tick();
    stop_i = 1'b0; pause_i = 1'b0;
    expect_out("stop_pause", 3, 0, 0);
    tick();
    expect_out("stop_pause_idle", 3, 0, 0);

    // zero load
    start_run(0, 5, 1'b0);
    expect_out("zero", 0, 0, 1);
    tick();
    expect_out("zero_after", 0, 0, 0);

    // maximum L=15 P=15: done 240 edges after start
    start_run(15, 15, 1'b0);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 300) begin
      tick();
      edges++;
      if (edges == 15) expect_out("max_e15", 15, 1, 0);
      if (edges == 16) expect_out("max_e16", 14, 1, 0);
      if (done_o) seen = 1'b1;
    end
    check("max_seen", 32'(seen), 32'd1);
    check("max_edges", 32'(edges), 32'd240);
    expect_out("max_term", 0, 0, 1);

    // asynchronous reset mid-run with count 9
    start_run(9, 3, 1'b0);
    tick();
    expect_out("pre_rst", 9, 1, 0);
    #2 reset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0);
    #3 reset = 1'b1;
    tick();
    expect_out("post_rst_idle", 0, 0, 0);
    start_run(2, 0, 1'b0);
    expect_out("pr_2", 2, 1, 0);
    tick();
    expect_out("pr_1", 1, 1, 0);
    tick();
    expect_out("pr_0", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
